program_sequencer: RTL and testbench

//   Parametrised instruction-address generator for the downsampling processor.

---
 rtl/program_sequencer.sv | 113 +++++++++++
 tb/tb_program_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Instruction-address generator with stall, halt and a hardware call/return
// stack. The address and all control state are registered, so no input
// reaches an output combinationally.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | accepting commands from the control unit
// ST_HALTED  | frozen after halt, overflow or underflow; only reset exits
module program_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               jmp,
    input  logic               call,
    input  logic               ret,
    input  logic               halt,
    input  logic [ADDR_W-1:0]  jmp_addr,
    output logic [ADDR_W-1:0]  addr_out,
    output logic [DEPTH_W-1:0] stack_depth,
    output logic               halted,
    output logic [1:0]         fault
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  addr_next;
    logic [DEPTH_W-1:0] depth_next;
    logic [1:0]         fault_next;
    logic               push;
    logic [ADDR_W-1:0]  stack_top;
    logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

    // Stack top is the entry just below the current depth; zero when empty.
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (stack_depth == DEPTH_W'(i + 1)) begin
                stack_top = stack_mem[i];
            end
        end
    end

    // Command decode in priority order: halted > stall > halt > ret > call > jmp > increment.
    always_comb begin
        state_next = state;
        addr_next  = addr_out;
        depth_next = stack_depth;
        fault_next = fault;
        push       = 1'b0;
        if (state == ST_RUN && !stall) begin
            if (halt) begin
                state_next = ST_HALTED;
            end else if (ret) begin
                if (stack_depth != '0) begin
                    addr_next  = stack_top;
                    depth_next = stack_depth - DEPTH_W'(1);
                end else begin
                    fault_next[1] = 1'b1;
                    state_next    = ST_HALTED;
                end
            end else if (call) begin
                if (stack_depth != DEPTH_W'(STACK_DEPTH)) begin
                    push       = 1'b1;
                    depth_next = stack_depth + DEPTH_W'(1);
                    addr_next  = jmp_addr;
                end else begin
                    fault_next[0] = 1'b1;
                    state_next    = ST_HALTED;
                end
            end else if (jmp) begin
                addr_next = jmp_addr;
            end else begin
                addr_next = addr_out + ADDR_W'(1);
            end
        end
    end

    // Control state register; reset clears everything except stack contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            addr_out    <= RESET_ADDR;
            stack_depth <= '0;
            fault       <= 2'b00;
        end else begin
            state       <= state_next;
            addr_out    <= addr_next;
            stack_depth <= depth_next;
            fault       <= fault_next;
        end
    end

    // Return-address storage; contents are meaningless after reset so no reset term.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && stack_depth == DEPTH_W'(i)) begin
                stack_mem[i] <= addr_out + ADDR_W'(1);
            end
        end
    end

    assign halted = (state == ST_HALTED);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: a vector table for the straight-line
// address flow, then hand sequences for overflow, underflow, halt, stall and
// asynchronous reset.
module tb_program_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall, jmp, call, ret, halt;
    logic [11:0] jmp_addr;
    logic [11:0] addr_out;
    logic [2:0]  stack_depth;
    logic        halted;
    logic [1:0]  fault;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        s, j, c, r, h;
        logic [11:0] ja;
        logic [11:0] ea;
        logic [2:0]  ed;
        logic        eh;
        logic [1:0]  ef;
    } vec_t;

    vec_t tbl[$];

    program_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .jmp         (jmp),
        .call        (call),
        .ret         (ret),
        .halt        (halt),
        .jmp_addr    (jmp_addr),
        .addr_out    (addr_out),
        .stack_depth (stack_depth),
        .halted      (halted),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [11:0] ea, input logic [2:0] ed,
                           input logic eh, input logic [1:0] ef);
        chk({tag, ".addr"},   32'(addr_out),    32'(ea));
        chk({tag, ".depth"},  32'(stack_depth), 32'(ed));
        chk({tag, ".halted"}, 32'(halted),      32'(eh));
        chk({tag, ".fault"},  32'(fault),       32'(ef));
    endtask

    // Drive one command, let one rising edge pass, check just after it.
    task automatic step(input string tag, input logic s, j, c, r, h, input logic [11:0] ja,
                        input logic [11:0] ea, input logic [2:0] ed,
                        input logic eh, input logic [1:0] ef);
        stall = s; jmp = j; call = c; ret = r; halt = h; jmp_addr = ja;
        @(posedge clk);
        #1;
        chk_all(tag, ea, ed, eh, ef);
    endtask

    // Pulse reset in the high phase of the clock, well away from any edge.
    task automatic pulse_reset(input string tag);
        #1 rst_n = 1'b0;
        stall = 0; jmp = 0; call = 0; ret = 0; halt = 0; jmp_addr = '0;
        #1 chk_all(tag, 12'h000, 3'd0, 1'b0, 2'b00);
        #1 rst_n = 1'b1;
    endtask

    function automatic vec_t v(input logic s, j, c, r, h, input logic [11:0] ja,
                               input logic [11:0] ea, input logic [2:0] ed);
        vec_t x;
        x.s = s; x.j = j; x.c = c; x.r = r; x.h = h; x.ja = ja;
        x.ea = ea; x.ed = ed; x.eh = 1'b0; x.ef = 2'b00;
        return x;
    endfunction

    initial begin
        rst_n = 1'b1;
        stall = 0; jmp = 0; call = 0; ret = 0; halt = 0; jmp_addr = '0;

        //                   s j c r h  ja       exp addr  depth
        tbl.push_back(v(0,0,0,0,0, 12'h000, 12'h001, 3'd0));
        tbl.push_back(v(0,0,0,0,0, 12'h000, 12'h002, 3'd0));
        tbl.push_back(v(0,0,0,0,0, 12'h000, 12'h003, 3'd0));
        tbl.push_back(v(0,0,0,0,0, 12'h000, 12'h004, 3'd0));
        tbl.push_back(v(0,0,0,0,0, 12'h000, 12'h005, 3'd0));
        tbl.push_back(v(0,1,0,0,0, 12'h010, 12'h010, 3'd0));
        tbl.push_back(v(0,0,1,0,0, 12'h200, 12'h200, 3'd1));
        tbl.push_back(v(0,0,0,0,0, 12'h000, 12'h201, 3'd1));
        tbl.push_back(v(0,0,0,0,0, 12'h000, 12'h202, 3'd1));
        tbl.push_back(v(0,0,0,0,0, 12'h000, 12'h203, 3'd1));
        tbl.push_back(v(0,0,0,1,0, 12'h000, 12'h011, 3'd0));
        tbl.push_back(v(0,1,0,0,0, 12'hFFE, 12'hFFE, 3'd0));
        tbl.push_back(v(0,0,0,0,0, 12'h000, 12'hFFF, 3'd0));
        tbl.push_back(v(0,0,0,0,0, 12'h000, 12'h000, 3'd0));
        tbl.push_back(v(0,1,0,0,0, 12'hFFF, 12'hFFF, 3'd0));
        tbl.push_back(v(0,0,1,0,0, 12'h123, 12'h123, 3'd1));
        tbl.push_back(v(0,0,0,1,0, 12'h000, 12'h000, 3'd0));
        tbl.push_back(v(0,1,1,0,0, 12'h050, 12'h050, 3'd1));
        tbl.push_back(v(0,1,1,1,0, 12'h0AA, 12'h001, 3'd0));

        #2 rst_n = 1'b0;
        #1 chk_all("reset", 12'h000, 3'd0, 1'b0, 2'b00);
        #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].s, tbl[i].j, tbl[i].c, tbl[i].r, tbl[i].h,
                 tbl[i].ja, tbl[i].ea, tbl[i].ed, tbl[i].eh, tbl[i].ef);
        end

        // Overflow: four nested calls fill the stack, the fifth freezes everything.
        step("call1", 0,0,1,0,0, 12'h100, 12'h100, 3'd1, 1'b0, 2'b00);
        step("call2", 0,0,1,0,0, 12'h200, 12'h200, 3'd2, 1'b0, 2'b00);
        step("call3", 0,0,1,0,0, 12'h300, 12'h300, 3'd3, 1'b0, 2'b00);
        step("call4", 0,0,1,0,0, 12'h400, 12'h400, 3'd4, 1'b0, 2'b00);
        step("call5", 0,0,1,0,0, 12'h500, 12'h400, 3'd4, 1'b1, 2'b01);
        step("ovf_jmp", 0,1,0,0,0, 12'h777, 12'h400, 3'd4, 1'b1, 2'b01);
        step("ovf_ret", 0,0,0,1,0, 12'h000, 12'h400, 3'd4, 1'b1, 2'b01);
        pulse_reset("rst_ovf");

        // Underflow: ret with an empty stack.
        step("udf", 0,0,0,1,0, 12'h000, 12'h000, 3'd0, 1'b1, 2'b10);
        step("udf_idle", 0,0,0,0,0, 12'h000, 12'h000, 3'd0, 1'b1, 2'b10);
        pulse_reset("rst_udf");

        // Plain halt beats a simultaneous jmp and sets no fault.
        step("pre_halt", 0,0,0,0,0, 12'h000, 12'h001, 3'd0, 1'b0, 2'b00);
        step("halt", 0,1,0,0,1, 12'h333, 12'h001, 3'd0, 1'b1, 2'b00);
        step("halt_hold", 0,0,0,0,0, 12'h000, 12'h001, 3'd0, 1'b1, 2'b00);
        pulse_reset("rst_halt");

        // Stall holds address, depth and stack contents for three cycles.
        step("pre_stall", 0,0,0,0,0, 12'h000, 12'h001, 3'd0, 1'b0, 2'b00);
        step("stall_call", 0,0,1,0,0, 12'h080, 12'h080, 3'd1, 1'b0, 2'b00);
        step("stall1", 1,1,0,0,0, 12'h300, 12'h080, 3'd1, 1'b0, 2'b00);
        step("stall2", 1,1,0,0,0, 12'h300, 12'h080, 3'd1, 1'b0, 2'b00);
        step("stall3", 1,1,1,1,1, 12'h300, 12'h080, 3'd1, 1'b0, 2'b00);
        step("post_stall_ret", 0,0,0,0,0, 12'h000, 12'h081, 3'd1, 1'b0, 2'b00);
        step("stall_ret", 0,0,0,1,0, 12'h000, 12'h002, 3'd0, 1'b0, 2'b00);
        step("run", 0,0,0,0,0, 12'h000, 12'h003, 3'd0, 1'b0, 2'b00);
        step("run_call", 0,0,1,0,0, 12'h040, 12'h040, 3'd1, 1'b0, 2'b00);
        pulse_reset("rst_mid");
        step("after_rst", 0,0,0,0,0, 12'h000, 12'h001, 3'd0, 1'b0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
